fetch_queue: RTL and testbench

- Small instruction FIFO directly downstream of the fetch stage; decouples fetch from decode.
- Each entry captures a fetched {PC, NPC, IR} triple; decode pops from the head.
- Provides the stall signal back to fetch when full, and discards all buffered wrong-path instructions on a taken branch.

---
 rtl/fetch_queue_pkg.sv | 25 ++
 rtl/fetch_queue_if.sv | 40 ++++
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: the buffered entry
// layout, the default depth and the bubble instruction word.
package fetch_queue_pkg;

  localparam int FQ_DEPTH_DEFAULT = 4;

  // Canonical no-op (addi x0, x0, 0), shown to decode when the queue is empty.
  localparam logic [31:0] NOOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ir;
  } fq_entry_t;

  // Entry presented at the head when nothing is buffered.
  function automatic fq_entry_t fq_bubble();
    fq_entry_t b;
    b.pc  = '0;
    b.npc = '0;
    b.ir  = NOOP_INST;
    return b;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode/execute-facing bundle of the fetch queue. The slave modport
// is the queue itself; the master modport is whatever drives it.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT
) ();

  // Fetch side
  logic                     if_valid_inst_in;
  logic [31:0]              if_PC_in;
  logic [31:0]              if_NPC_in;
  logic [31:0]              if_IR_in;
  // Execute side
  logic                     ex_take_branch_in;
  // Decode side
  logic                     id_ready_in;
  // Queue outputs
  logic                     fq_stall_out;
  logic                     fq_valid_out;
  logic [31:0]              fq_PC_out;
  logic [31:0]              fq_NPC_out;
  logic [31:0]              fq_IR_out;
  logic [$clog2(DEPTH):0]   fq_count_out;

  modport slave (
    input  if_valid_inst_in, if_PC_in, if_NPC_in, if_IR_in,
    input  ex_take_branch_in, id_ready_in,
    output fq_stall_out, fq_valid_out, fq_PC_out, fq_NPC_out, fq_IR_out,
    output fq_count_out
  );

  modport master (
    output if_valid_inst_in, if_PC_in, if_NPC_in, if_IR_in,
    output ex_take_branch_in, id_ready_in,
    input  fq_stall_out, fq_valid_out, fq_PC_out, fq_NPC_out, fq_IR_out,
    input  fq_count_out
  );

endinterface

// File: rtl/fetch_queue.sv
// Instruction FIFO between fetch and decode. Buffers {PC, NPC, IR} triples,
// stalls fetch when full and discards everything buffered on a taken branch.
// Head outputs are read combinationally from the entry at rd_ptr.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.slave   fq
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  fq_entry_t wr_entry;
  fq_entry_t head;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // No push while full even if decode pops this cycle: fetch keeps presenting
  // the same instruction while stalled, so accepting it now would duplicate it.
  assign push = fq.if_valid_inst_in & ~full  & ~fq.ex_take_branch_in;
  assign pop  = fq.id_ready_in      & ~empty & ~fq.ex_take_branch_in;

  assign wr_entry.pc  = fq.if_PC_in;
  assign wr_entry.npc = fq.if_NPC_in;
  assign wr_entry.ir  = fq.if_IR_in;

  // Next-state for pointers and occupancy; a flush empties the queue by
  // snapping the read pointer onto the write pointer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fq.ex_take_branch_in) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset drops all entries immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr,
  // so the array is never cleared.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head presentation: a bubble when empty so decode never sees stale data.
  always_comb begin
    head = mem_q[rd_ptr_q];
    if (empty) head = fq_bubble();
  end

  assign fq.fq_stall_out = full;
  assign fq.fq_valid_out = ~empty;
  assign fq.fq_PC_out    = head.pc;
  assign fq.fq_NPC_out   = head.npc;
  assign fq.fq_IR_out    = head.ir;
  assign fq.fq_count_out = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a hand-derived vector table for the
// fill/full/drain path, directed sequences for streaming, flush, empty pops
// and async reset, then randomized traffic against a queue-based model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) fq_bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq_bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the buffered entries in order, head at index 0.
  fq_entry_t mq[$];

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        rdy;
    logic        br;
    int          e_cnt;
    logic        e_valid;
    logic        e_stall;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[14];

  function automatic fq_entry_t mk(logic [31:0] pc);
    fq_entry_t e;
    e.pc  = pc;
    e.npc = pc + 32'd4;
    e.ir  = 32'hA500_0000 ^ pc;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances with the same inputs.
  task automatic step(logic v, logic [31:0] pc, logic rdy, logic br);
    fq_entry_t e;
    bit        was_full;
    e = mk(pc);
    fq_bus.if_valid_inst_in  = v;
    fq_bus.if_PC_in          = e.pc;
    fq_bus.if_NPC_in         = e.npc;
    fq_bus.if_IR_in          = e.ir;
    fq_bus.id_ready_in       = rdy;
    fq_bus.ex_take_branch_in = br;
    if (br) begin
      mq.delete();
    end else begin
      was_full = (mq.size() == DEPTH);
      if (rdy && mq.size() != 0) mq.delete(0);
      if (v && !was_full) mq.push_back(e);
    end
    @(posedge clk);
    #1;
    $display("txn t=%0t v=%0b pc=%h rdy=%0b br=%0b -> cnt=%0d valid=%0b stall=%0b head_pc=%h",
             $time, v, pc, rdy, br, fq_bus.fq_count_out, fq_bus.fq_valid_out,
             fq_bus.fq_stall_out, fq_bus.fq_PC_out);
  endtask

  task automatic check_model(string tag);
    fq_entry_t h;
    int        n;
    n = mq.size();
    if (n != 0) begin
      h = mq[0];
    end else begin
      h.pc  = 32'd0;
      h.npc = 32'd0;
      h.ir  = NOOP_INST;
    end
    chk({tag, ".count"}, 32'(fq_bus.fq_count_out), n[31:0]);
    chk({tag, ".valid"}, 32'(fq_bus.fq_valid_out), (n != 0) ? 32'd1 : 32'd0);
    chk({tag, ".stall"}, 32'(fq_bus.fq_stall_out), (n == DEPTH) ? 32'd1 : 32'd0);
    chk({tag, ".pc"},    fq_bus.fq_PC_out,  h.pc);
    chk({tag, ".npc"},   fq_bus.fq_NPC_out, h.npc);
    chk({tag, ".ir"},    fq_bus.fq_IR_out,  h.ir);
  endtask

  task automatic check_empty_outputs(string tag);
    chk({tag, ".count"}, 32'(fq_bus.fq_count_out), 32'd0);
    chk({tag, ".valid"}, 32'(fq_bus.fq_valid_out), 32'd0);
    chk({tag, ".stall"}, 32'(fq_bus.fq_stall_out), 32'd0);
    chk({tag, ".pc"},    fq_bus.fq_PC_out,  32'd0);
    chk({tag, ".npc"},   fq_bus.fq_NPC_out, 32'd0);
    chk({tag, ".ir"},    fq_bus.fq_IR_out,  NOOP_INST);
  endtask

  initial begin
    fq_bus.if_valid_inst_in  = 1'b0;
    fq_bus.if_PC_in          = '0;
    fq_bus.if_NPC_in         = '0;
    fq_bus.if_IR_in          = '0;
    fq_bus.id_ready_in       = 1'b0;
    fq_bus.ex_take_branch_in = 1'b0;

    // Fill, hold a 5th instruction while full, pop one and let it in, drain.
    //              v     pc        rdy   br    cnt valid stall head_pc
    tbl[0]  = '{1'b1, 32'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 32'h04, 1'b0, 1'b0, 2, 1'b1, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 32'h08, 1'b0, 1'b0, 3, 1'b1, 1'b0, 32'h00};
    tbl[3]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 4, 1'b1, 1'b1, 32'h00};
    tbl[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 4, 1'b1, 1'b1, 32'h00};
    tbl[5]  = '{1'b1, 32'h10, 1'b0, 1'b0, 4, 1'b1, 1'b1, 32'h00};
    tbl[6]  = '{1'b1, 32'h10, 1'b0, 1'b0, 4, 1'b1, 1'b1, 32'h00};
    tbl[7]  = '{1'b1, 32'h10, 1'b1, 1'b0, 3, 1'b1, 1'b0, 32'h04};
    tbl[8]  = '{1'b1, 32'h10, 1'b0, 1'b0, 4, 1'b1, 1'b1, 32'h04};
    tbl[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 3, 1'b1, 1'b0, 32'h08};
    tbl[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 2, 1'b1, 1'b0, 32'h0C};
    tbl[11] = '{1'b0, 32'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 32'h10};
    tbl[12] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h00};
    tbl[13] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h00};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_empty_outputs("reset");
    rst = 1'b0;

    // Table-driven fill / full / drain
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].pc, tbl[i].rdy, tbl[i].br);
      chk($sformatf("tbl%0d.count", i), 32'(fq_bus.fq_count_out), tbl[i].e_cnt[31:0]);
      chk($sformatf("tbl%0d.valid", i), 32'(fq_bus.fq_valid_out), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.stall", i), 32'(fq_bus.fq_stall_out), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d.pc", i), fq_bus.fq_PC_out, tbl[i].e_pc);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d.npc", i), fq_bus.fq_NPC_out, tbl[i].e_pc + 32'd4);
        chk($sformatf("tbl%0d.ir", i), fq_bus.fq_IR_out, 32'hA500_0000 ^ tbl[i].e_pc);
      end else begin
        chk($sformatf("tbl%0d.npc", i), fq_bus.fq_NPC_out, 32'd0);
        chk($sformatf("tbl%0d.ir", i), fq_bus.fq_IR_out, NOOP_INST);
      end
    end

    // Steady stream: one push then push+pop every cycle, pointers wrap
    step(1'b1, 32'h00, 1'b0, 1'b0);
    check_model("stream0");
    for (int i = 1; i < 12; i++) begin
      step(1'b1, 32'(4 * i), 1'b1, 1'b0);
      chk($sformatf("stream%0d.count", i), 32'(fq_bus.fq_count_out), 32'd1);
      chk($sformatf("stream%0d.pc", i), fq_bus.fq_PC_out, 32'(4 * i));
      check_model($sformatf("stream%0d", i));
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_model("stream_drain");

    // Flush with 3 entries held and push+pop requested in the same cycle
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h44, 1'b0, 1'b0);
    step(1'b1, 32'h48, 1'b0, 1'b0);
    check_model("flush_pre");
    step(1'b1, 32'h20, 1'b1, 1'b1);
    check_empty_outputs("flush");
    step(1'b1, 32'h100, 1'b0, 1'b0);
    chk("flush_tgt.count", 32'(fq_bus.fq_count_out), 32'd1);
    chk("flush_tgt.pc", fq_bus.fq_PC_out, 32'h100);
    check_model("flush_tgt");
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while full releases the stall the next cycle
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(32'h500 + 4 * i), 1'b0, 1'b0);
    chk("full_pre.stall", 32'(fq_bus.fq_stall_out), 32'd1);
    step(1'b1, 32'h600, 1'b0, 1'b1);
    check_empty_outputs("full_flush");

    // Pops on an empty queue must not move anything
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check_empty_outputs($sformatf("empty_pop%0d", i));
    end
    step(1'b1, 32'h200, 1'b0, 1'b0);
    chk("after_empty.pc", fq_bus.fq_PC_out, 32'h200);
    chk("after_empty.ir", fq_bus.fq_IR_out, 32'hA500_0200);
    check_model("after_empty");
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_model("after_empty_pop");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 70, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 6);
      check_model($sformatf("rand%0d", i));
    end

    // Async reset mid-cycle with two entries held
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h308, 1'b0, 1'b0);
    chk("pre_rst.count", 32'(fq_bus.fq_count_out), 32'd2);
    fq_bus.if_valid_inst_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_empty_outputs("async_rst");
    mq.delete();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_empty_outputs("post_rst");
    step(1'b1, 32'h400, 1'b0, 1'b0);
    check_model("post_rst_push");
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_model("post_rst_pop");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
